// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encodings, oversample rate and defaults.
// Common to the tx and rx blocks so both ends of the link agree.
package uart_tx_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 163;
    localparam int DEF_DVSR_W  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// master = producer, slave = uart_tx.
interface uart_tx_if
    import uart_tx_pkg::*;
#(
    parameter int DBIT = DEF_DBIT
);

    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            tx_ready;
    logic            tx_done_tick;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx_done_tick
    );

endinterface

// File: rtl/uart_baud_gen.sv
// 16x baud tick generator; held at zero while disabled so each frame
// starts from a known phase.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int DVSR   = DEF_DVSR,
    parameter int DVSR_W = DEF_DVSR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] cnt_q;
    logic [DVSR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && cnt_q != LAST)
            cnt_d = cnt_q + 1'b1;
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, stop.
// Parity bit is built in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DBIT       = DEF_DBIT,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int DVSR       = DEF_DVSR,
    parameter int DVSR_W     = DEF_DVSR_W,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx
);

    localparam logic [5:0] S_LAST  = 6'(OVERSAMPLE - 1);
    localparam logic [5:0] SB_LAST = 6'(SB_TICK - 1);
    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

    state_t          state_q;
    state_t          state_d;
    logic [5:0]      s_q;
    logic [5:0]      s_d;
    logic [2:0]      n_q;
    logic [2:0]      n_d;
    logic [DBIT-1:0] b_q;
    logic [DBIT-1:0] b_d;
    logic            tx_q;
    logic            tx_d;
    logic            done;
    logic            tick;
    logic            par_q;
    logic            par_d;

    uart_baud_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    state_d = START;
                    s_d     = '0;
                    b_d     = bus.tx_data;
                    par_d   = ^bus.tx_data ^ PARITY_ODD;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        state_d = STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == SB_LAST) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // line level follows the state being entered, so tx is registered
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

`ifndef UART_TX_PARITY_EN
    logic unused_par;
    assign unused_par = par_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.tx_ready     = (state_q == IDLE);
    assign bus.tx_done_tick = done;
    assign tx               = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DVSR=4 (64 clks/bit), DBIT=8, 1 stop bit.
// Define UART_TX_PARITY_EN to also check even and odd parity instances.
module tb_uart_tx;

    localparam int DV     = 4;
    localparam int BITCLK = 16 * DV;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FR = NB * BITCLK;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx;
    int   nchk  = 0;
    int   nerr  = 0;

    uart_tx_if #(.DBIT(8)) bus();

    uart_tx #(
        .DBIT       (8),
        .SB_TICK    (16),
        .DVSR       (DV),
        .DVSR_W     (8),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

`ifdef UART_TX_PARITY_EN
    logic tx2;
    logic par_seen;
    logic par2_seen;

    uart_tx_if #(.DBIT(8)) bus2();
    assign bus2.tx_start = bus.tx_start;
    assign bus2.tx_data  = bus.tx_data;

    uart_tx #(
        .DBIT       (8),
        .SB_TICK    (16),
        .DVSR       (DV),
        .DVSR_W     (8),
        .PARITY_ODD (1'b1)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2),
        .tx    (tx2)
    );
`endif

    always #5 clk = ~clk;

    function automatic logic fbit(input logic [7:0] d,
                                  input int i, input bit odd);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9 && NB == 11) return ^d ^ odd;
        return 1'b1;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Sends d and checks every cycle of the frame; optionally pokes
    // tx_start/tx_data mid-frame, or keeps tx_start high afterwards.
    task automatic run_frame(input logic [7:0] d, input bit hold,
                             input bit poke, input logic [7:0] pd,
                             input string tag);
        int err  = 0;
        int dcnt = 0;
        int dat  = -1;
        chk({tag, " rdy"}, 32'(bus.tx_ready), 32'd1);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        @(posedge clk); #1;
        if (!hold) bus.tx_start = 1'b0;
        for (int k = 0; k <= FR; k++) begin
            logic et;
            logic ed;
            logic er;
            et = (k < FR) ? fbit(d, k / BITCLK, 1'b0) : 1'b1;
            ed = (k == FR - 1);
            er = (k == FR);
            if (tx !== et || bus.tx_ready !== er) err++;
            if (bus.tx_done_tick !== ed) err++;
            if (bus.tx_done_tick === 1'b1) begin
                dcnt++;
                dat = k;
            end
`ifdef UART_TX_PARITY_EN
            if (k < FR && tx2 !== fbit(d, k / BITCLK, 1'b1)) err++;
            if (k == 9 * BITCLK + BITCLK / 2) begin
                par_seen  = tx;
                par2_seen = tx2;
            end
`endif
            if (poke && k == 200) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = pd;
            end
            if (poke && k == 201 && !hold) bus.tx_start = 1'b0;
            if (k < FR) begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " cyc err"}, 32'(err), 32'd0);
        chk({tag, " done cnt"}, 32'(dcnt), 32'd1);
        chk({tag, " done at"}, 32'(dat), 32'(FR - 1));
    endtask

    initial begin
        int dc;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        reset        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst rdy", 32'(bus.tx_ready), 32'd1);
        chk("rst done", 32'(bus.tx_done_tick), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rel tx", 32'(tx), 32'd1);
        chk("rel rdy", 32'(bus.tx_ready), 32'd1);
        chk("rel done", 32'(bus.tx_done_tick), 32'd0);

        run_frame(8'hA5, 1'b0, 1'b1, 8'hFF, "a5");
        repeat (5) @(posedge clk);
        #1;
        chk("idle tx", 32'(tx), 32'd1);

        run_frame(8'h00, 1'b1, 1'b1, 8'h55, "b2b 00");
        run_frame(8'h55, 1'b0, 1'b0, 8'h00, "b2b 55");

        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h3C;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("mid busy", 32'(bus.tx_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid rst tx", 32'(tx), 32'd1);
        chk("mid rst rdy", 32'(bus.tx_ready), 32'd1);
        dc = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.tx_done_tick !== 1'b0) dc++;
            if (tx !== 1'b1) dc++;
        end
        chk("mid rst quiet", 32'(dc), 32'd0);
        @(negedge clk) reset = 1'b1;
        run_frame(8'h3C, 1'b0, 1'b0, 8'h00, "3c");

`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, 1'b0, 1'b0, 8'h00, "p07");
        chk("par even 07", 32'(par_seen), 32'd1);
        chk("par odd 07", 32'(par2_seen), 32'd0);
        run_frame(8'h03, 1'b0, 1'b0, 8'h00, "p03");
        chk("par even 03", 32'(par_seen), 32'd0);
        chk("par odd 03", 32'(par2_seen), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nchk, nerr);
        $finish;
    end

endmodule
